// File: rtl/vga_sync.sv
// vga_sync: 640x480 @ 60 Hz raster timing generator with a pixel-rate enable tick.
// hsync/vsync/video_on are registered from the next-state counters so they change on the same edge as x/y.
module vga_sync #(
   parameter int unsigned TICK_DIV  = 4,
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       p_tick,
   output logic       frame_start,
   output logic [9:0] x,
   output logic [9:0] y
);

   localparam int unsigned H_MAX = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
   localparam int unsigned V_MAX = V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1;
   localparam int unsigned DIV_W = $clog2(TICK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
   localparam logic [9:0]       H_MAX_C    = 10'(H_MAX);
   localparam logic [9:0]       V_MAX_C    = 10'(V_MAX);
   localparam logic [9:0]       H_DISP_C   = 10'(H_DISPLAY);
   localparam logic [9:0]       V_DISP_C   = 10'(V_DISPLAY);
   localparam logic [9:0]       HS_START_C = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0]       HS_END_C   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0]       VS_START_C = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0]       VS_END_C   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             video_on_q, video_on_d;
   logic             p_tick_q, p_tick_d;
   logic             frame_start_q, frame_start_d;
   logic             tick;

   always_comb begin
      tick  = (div_q == DIV_LAST);
      div_d = tick ? '0 : div_q + DIV_W'(1);

      x_d = x_q;
      y_d = y_q;
      if (tick) begin
         if (x_q == H_MAX_C) begin
            x_d = '0;
            y_d = (y_q == V_MAX_C) ? '0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end

      // Decoding x_d/y_d rather than x_q/y_q keeps the registered syncs aligned with the counters.
      hsync_d       = !((x_d >= HS_START_C) && (x_d <= HS_END_C));
      vsync_d       = !((y_d >= VS_START_C) && (y_d <= VS_END_C));
      video_on_d    = (x_d < H_DISP_C) && (y_d < V_DISP_C);
      p_tick_d      = tick;
      frame_start_d = tick && (x_q == H_MAX_C) && (y_q == V_MAX_C);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         video_on_q    <= 1'b1;
         p_tick_q      <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         x_q           <= x_d;
         y_q           <= y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         p_tick_q      <= p_tick_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign p_tick      = p_tick_q;
   assign frame_start = frame_start_q;
   assign x           = x_q;
   assign y           = y_q;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: default 640x480 instance plus a tiny-raster instance, checked every clock
// against an arithmetic model driven by the number of clock edges since reset release.
module tb_vga_sync;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   logic       hs_a, vs_a, vo_a, pt_a, fs_a;
   logic [9:0] x_a, y_a;
   logic       hs_b, vs_b, vo_b, pt_b, fs_b;
   logic [9:0] x_b, y_b;

   vga_sync u_dut_a (
      .clk(clk), .reset(rst_a), .hsync(hs_a), .vsync(vs_a), .video_on(vo_a),
      .p_tick(pt_a), .frame_start(fs_a), .x(x_a), .y(y_a)
   );

   vga_sync #(
      .TICK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
      .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
   ) u_dut_b (
      .clk(clk), .reset(rst_b), .hsync(hs_b), .vsync(vs_b), .video_on(vo_b),
      .p_tick(pt_b), .frame_start(fs_b), .x(x_b), .y(y_b)
   );

   // Clock edges seen since each instance last left reset.
   longint k_a = 0;
   longint k_b = 0;
   always @(posedge clk or posedge rst_a) if (rst_a) k_a <= 0; else k_a <= k_a + 1;
   always @(posedge clk or posedge rst_b) if (rst_b) k_b <= 0; else k_b <= k_b + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   // Raster position follows from the number of completed pixel ticks.
   function automatic void ref_out(
      input int td, input int hd, input int hf, input int hs, input int hb,
      input int vd, input int vf, input int vs, input int vb, input longint k,
      output longint xr, output longint yr, output logic hsr, output logic vsr,
      output logic vor, output logic ptr, output logic fsr);
      longint ht, vt, p;
      ht  = hd + hf + hs + hb;
      vt  = vd + vf + vs + vb;
      p   = k / td;
      xr  = p % ht;
      yr  = (p / ht) % vt;
      ptr = (k > 0) && (k % td == 0);
      fsr = ptr && (p % (ht * vt) == 0);
      hsr = !((xr >= hd + hf) && (xr < hd + hf + hs));
      vsr = !((yr >= vd + vf) && (yr < vd + vf + vs));
      vor = (xr < hd) && (yr < vd);
   endfunction

   task automatic cmp_a();
      longint xr, yr;
      logic h, v, o, p, f;
      ref_out(4, 640, 16, 96, 48, 480, 10, 2, 33, k_a, xr, yr, h, v, o, p, f);
      check("A.x", x_a, xr);
      check("A.y", y_a, yr);
      check("A.hsync", hs_a, h);
      check("A.vsync", vs_a, v);
      check("A.video_on", vo_a, o);
      check("A.p_tick", pt_a, p);
      check("A.frame_start", fs_a, f);
   endtask

   task automatic cmp_b();
      longint xr, yr;
      logic h, v, o, p, f;
      ref_out(2, 8, 2, 2, 2, 4, 1, 1, 1, k_b, xr, yr, h, v, o, p, f);
      check("B.x", x_b, xr);
      check("B.y", y_b, yr);
      check("B.hsync", hs_b, h);
      check("B.vsync", vs_b, v);
      check("B.video_on", vo_b, o);
      check("B.p_tick", pt_b, p);
      check("B.frame_start", fs_b, f);
   endtask

   logic   meas_en   = 1'b0;
   logic   pt_prev_a = 1'b0;
   logic   pt_prev_b = 1'b0;
   int     hs_run    = 0;
   int     pt_count  = 0;
   longint cyc       = 0;
   longint last_fs   = -1;

   task automatic step();
      @(negedge clk);
      cyc++;
      cmp_a();
      cmp_b();
      if (pt_a) check("A.p_tick_consecutive", pt_prev_a, 0);
      if (pt_b) check("B.p_tick_consecutive", pt_prev_b, 0);
      pt_prev_a = pt_a;
      pt_prev_b = pt_b;
      if (meas_en) begin
         if (pt_a) pt_count++;
         if (!hs_a) hs_run++;
         else if (hs_run > 0) begin
            check("A.hsync_low_clks", hs_run, 384);
            hs_run = 0;
         end
         if (fs_b) begin
            if (last_fs >= 0) check("B.frame_period", cyc - last_fs, 196);
            last_fs = cyc;
         end
      end
   endtask

   initial begin
      logic found;
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (3) step();

      // Release both and run past two full default lines.
      rst_a   = 1'b0;
      rst_b   = 1'b0;
      cyc     = 0;
      meas_en = 1'b1;
      repeat (7000) step();
      meas_en = 1'b0;
      check("A.p_tick_count_7000", pt_count, 1750);
      check("B.frame_seen", (last_fs >= 0) ? 1 : 0, 1);

      // Mid-line asynchronous reset of the default instance at x = 300.
      found = 1'b0;
      for (int i = 0; i < 4000 && !found; i++) begin
         step();
         if (x_a == 10'd300) found = 1'b1;
      end
      check("A.reached_x300", found, 1);
      @(posedge clk);
      #2 rst_a = 1'b1;
      #1 cmp_a();
      check("A.async_x", x_a, 0);
      check("A.async_hsync", hs_a, 1);
      repeat (3) step();
      rst_a = 1'b0;
      repeat (20) step();

      // Randomly timed asynchronous resets of the small instance.
      repeat (50) begin
         repeat ($urandom_range(1, 450)) step();
         @(posedge clk);
         #($urandom_range(1, 3)) rst_b = 1'b1;
         #1 cmp_b();
         repeat ($urandom_range(1, 3)) step();
         rst_b = 1'b0;
      end
      repeat (50) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
